// File: rtl/intro_input_conditioner.sv
// Input conditioner: per-channel N_SYNC-deep synchroniser followed by a counting debouncer.
// Produces glitch-free A..D plus a registered change pulse and a settled indicator.
module intro_input_conditioner #(
    parameter int unsigned N_SYNC    = 2,
    parameter int unsigned DB_CNT_W  = 16,
    parameter int unsigned DB_CYCLES = 1000,
    parameter logic [3:0]  RST_VAL   = 4'b0000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] RawIn,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       Changed,
    output logic       Stable
);

    localparam int unsigned NCH = 4;
    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);
    localparam logic [DB_CNT_W-1:0] CNT_ONE  = DB_CNT_W'(1);

    logic [NCH-1:0][N_SYNC-1:0]   sync_q;
    logic [NCH-1:0][N_SYNC-1:0]   sync_d;
    logic [NCH-1:0][DB_CNT_W-1:0] cnt_q;
    logic [NCH-1:0][DB_CNT_W-1:0] cnt_d;
    logic [NCH-1:0]               out_q;
    logic [NCH-1:0]               out_d;
    logic                         changed_q;
    logic                         changed_d;
    logic                         stable_q;
    logic                         stable_d;

    // Synchroniser shift: plain flop chain, raw input enters at stage 0.
    always_comb begin
        sync_d = sync_q;
        for (int i = 0; i < NCH; i++) begin
            sync_d[i] = {sync_q[i][N_SYNC-2:0], RawIn[i]};
        end
    end

    // Debounce: accept the synchronised level only after DB_CYCLES consecutive mismatches.
    always_comb begin
        out_d = out_q;
        cnt_d = cnt_q;
        for (int i = 0; i < NCH; i++) begin
            if (sync_q[i][N_SYNC-1] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                out_d[i] = sync_q[i][N_SYNC-1];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Status flags are registered alongside the outputs they describe.
    always_comb begin
        changed_d = |(out_d ^ out_q);
        stable_d  = (cnt_d == '0);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NCH; i++) begin
                sync_q[i] <= {N_SYNC{RST_VAL[i]}};
            end
            cnt_q     <= '0;
            out_q     <= RST_VAL;
            changed_q <= 1'b0;
            stable_q  <= 1'b1;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            changed_q <= changed_d;
            stable_q  <= stable_d;
        end
    end

    assign A       = out_q[0];
    assign B       = out_q[1];
    assign C       = out_q[2];
    assign D       = out_q[3];
    assign Changed = changed_q;
    assign Stable  = stable_q;

endmodule

// File: tb/tb_intro_input_conditioner.sv
// Bench for intro_input_conditioner: directed scenarios plus random bouncing inputs,
// compared every cycle against a run-length model of synchronise-then-debounce.
module tb_intro_input_conditioner;

    localparam int unsigned N_SYNC    = 2;
    localparam int unsigned DB_CNT_W  = 16;
    localparam int unsigned DB_CYCLES = 4;
    localparam logic [3:0]  RST_VAL   = 4'b0000;

    logic       clk;
    logic       rst;
    logic [3:0] raw_in;
    logic       a, b, c, d, changed, stable;

    int n_checks = 0;
    int n_pass   = 0;

    intro_input_conditioner #(
        .N_SYNC    (N_SYNC),
        .DB_CNT_W  (DB_CNT_W),
        .DB_CYCLES (DB_CYCLES),
        .RST_VAL   (RST_VAL)
    ) dut (
        .Clk     (clk),
        .Rst     (rst),
        .RawIn   (raw_in),
        .A       (a),
        .B       (b),
        .C       (c),
        .D       (d),
        .Changed (changed),
        .Stable  (stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the raw level seen N_SYNC edges late, and a mismatch run length per channel.
    logic [3:0] m_hist [N_SYNC];
    int         m_run  [4];
    logic [3:0] m_out;
    logic       m_chg;
    logic       m_stb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_step(input logic [3:0] raw, input logic r);
        logic [3:0] prev;
        logic       s;
        if (r) begin
            for (int k = 0; k < N_SYNC; k++) m_hist[k] = RST_VAL;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_out = RST_VAL;
            m_chg = 1'b0;
            m_stb = 1'b1;
        end else begin
            prev = m_out;
            for (int i = 0; i < 4; i++) begin
                s = m_hist[N_SYNC-1][i];
                if (s !== m_out[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB_CYCLES) begin
                        m_out[i] = s;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_chg = (prev != m_out);
            m_stb = (m_run[0] == 0) && (m_run[1] == 0) && (m_run[2] == 0) && (m_run[3] == 0);
            for (int k = N_SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = raw;
        end
    endtask

    // One clock: drive, clock the model with the DUT, compare mid-cycle.
    task automatic step(input string tag, input logic [3:0] raw, input logic r);
        raw_in = raw;
        rst    = r;
        @(posedge clk);
        model_step(raw, r);
        @(negedge clk);
        check({tag, ".A"},       32'(a),       32'(m_out[0]));
        check({tag, ".B"},       32'(b),       32'(m_out[1]));
        check({tag, ".C"},       32'(c),       32'(m_out[2]));
        check({tag, ".D"},       32'(d),       32'(m_out[3]));
        check({tag, ".Changed"}, 32'(changed), 32'(m_chg));
        check({tag, ".Stable"},  32'(stable),  32'(m_stb));
    endtask

    task automatic hold(input string tag, input logic [3:0] raw, input int n);
        for (int k = 0; k < n; k++) step(tag, raw, 1'b0);
    endtask

    initial begin
        logic [3:0] rv;
        int         n_changed;
        raw_in = 4'hF;
        rst    = 1'b1;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        @(negedge clk);

        // Reset with all inputs high, then first cycles after release.
        step("reset", 4'hF, 1'b1);
        step("reset", 4'hF, 1'b1);
        hold("post_reset", 4'h0, 8);

        // Single channel rise, then fall.
        hold("single_a", 4'h1, 10);
        check("single_a.level", 32'(a), 32'd1);
        hold("single_a_fall", 4'h0, 10);

        // Glitch shorter than the debounce window.
        hold("glitch_c", 4'h4, DB_CYCLES - 1);
        hold("glitch_c_end", 4'h0, 10);
        check("glitch_c.level", 32'(c), 32'd0);

        // Simultaneous B and D: exactly one Changed pulse.
        n_changed = 0;
        for (int k = 0; k < 10; k++) begin
            step("simul_bd", 4'hA, 1'b0);
            if (changed) n_changed++;
        end
        check("simul_bd.pulses", 32'(n_changed), 32'd1);
        check("simul_bd.abcd", 32'({d, c, b, a}), 32'hA);
        hold("simul_bd_fall", 4'h0, 10);

        // Reset in the middle of a count.
        hold("rst_mid", 4'h2, 4);
        step("rst_mid_rst", 4'h2, 1'b1);
        check("rst_mid.b_after_rst", 32'(b), 32'd0);
        hold("rst_mid_post", 4'h2, 10);
        hold("rst_mid_fall", 4'h0, 10);

        // Bounce on D, then settle high, then low.
        step("bounce_d", 4'h8, 1'b0);
        step("bounce_d", 4'h0, 1'b0);
        step("bounce_d", 4'h8, 1'b0);
        step("bounce_d", 4'h0, 1'b0);
        hold("bounce_d_hold1", 4'h8, 10);
        check("bounce_d.level_hi", 32'(d), 32'd1);
        hold("bounce_d_hold0", 4'h0, 10);
        check("bounce_d.level_lo", 32'(d), 32'd0);

        // Random bouncing inputs with occasional resets.
        rv = 4'h0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) rv[i] = ~rv[i];
            end
            step("random", rv, ($urandom_range(0, 299) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
